// File: rtl/fir_channel_scheduler.sv
// Two-channel (RED/IR) symmetric 22-tap low-pass FIR sharing one pre-add/multiply/accumulate unit.
// Each channel owns a one-entry holding register and a private delay line; a round-robin FSM grants service.
module fir_channel_scheduler #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int NTAPS  = 22
) (
  input  logic              CLK_Filter,
  input  logic              rst,
  input  logic              red_valid,
  input  logic [DATA_W-1:0] red_data,
  output logic              red_ready,
  input  logic              ir_valid,
  input  logic [DATA_W-1:0] ir_data,
  output logic              ir_ready,
  output logic              out_valid,
  output logic              out_ch,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy
);

  localparam int NSTEP  = NTAPS / 2;
  localparam int STEP_W = $clog2(NSTEP);
  localparam int IDX_W  = $clog2(NTAPS);
  localparam int COEF_W = 8;
  localparam int PROD_W = DATA_W + 1 + COEF_W;

  localparam logic [COEF_W-1:0] COEFS [NSTEP] = '{
    8'd2, 8'd10, 8'd16, 8'd28, 8'd43, 8'd60, 8'd78, 8'd95, 8'd111, 8'd122, 8'd128
  };

  typedef enum logic [1:0] {IDLE, SHIFT, MAC, DONE} state_t;

  state_t              state, state_nx;
  logic                grant, grant_nx;
  logic [STEP_W-1:0]   step;
  logic [ACC_W-1:0]    acc, acc_nx;
  logic [1:0]          hold_full;
  logic [DATA_W-1:0]   tap_lo [2];
  logic [DATA_W-1:0]   tap_hi [2];
  logic [IDX_W-1:0]    idx_lo, idx_hi;
  logic [PROD_W-1:0]   term;

  function automatic logic [PROD_W-1:0] mac_term(input logic [COEF_W-1:0] c,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] pre;
    pre = {1'b0, a} + {1'b0, b};
    return PROD_W'(c) * PROD_W'(pre);
  endfunction

  assign idx_lo = IDX_W'(step);
  assign idx_hi = IDX_W'(NTAPS - 1) - IDX_W'(step);
  assign term   = mac_term(COEFS[step], tap_lo[grant], tap_hi[grant]);
  assign acc_nx = acc + ACC_W'(term);

  // Per-channel holding register and delay line; only the granted channel is touched by SHIFT.
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              full;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] line [NTAPS];
    logic              shift_en;

    assign valid_in = (c == 0) ? red_valid : ir_valid;
    assign data_in  = (c == 0) ? red_data  : ir_data;
    assign shift_en = (state == SHIFT) && (grant == 1'(c));

    always_ff @(posedge CLK_Filter or posedge rst) begin
      if (rst) begin
        full <= 1'b0;
        hold <= '0;
      end else if (shift_en) begin
        full <= 1'b0;
      end else if (valid_in && !full) begin
        full <= 1'b1;
        hold <= data_in;
      end
    end

    always_ff @(posedge CLK_Filter or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < NTAPS; i++) line[i] <= '0;
      end else if (shift_en) begin
        line[0] <= hold;
        for (int i = 1; i < NTAPS; i++) line[i] <= line[i-1];
      end
    end

    assign hold_full[c] = full;
    assign tap_lo[c]    = line[idx_lo];
    assign tap_hi[c]    = line[idx_hi];
  end

  assign red_ready = !hold_full[0];
  assign ir_ready  = !hold_full[1];
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK_Filter or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    case (state)
      IDLE: begin
        if (hold_full != 2'b00) begin
          state_nx = SHIFT;
          // On a tie, serve the channel that was not served last.
          grant_nx = (hold_full == 2'b11) ? ~grant : hold_full[1];
        end
      end
      SHIFT:   state_nx = MAC;
      MAC:     if (step == STEP_W'(NSTEP - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK_Filter or posedge rst) begin
    if (rst) begin
      grant    <= 1'b1;
      step     <= '0;
      acc      <= '0;
      out_ch   <= 1'b0;
      out_data <= '0;
    end else begin
      grant <= grant_nx;
      case (state)
        SHIFT: begin
          acc  <= '0;
          step <= '0;
        end
        MAC: begin
          acc  <= acc_nx;
          step <= step + 1'b1;
          if (step == STEP_W'(NSTEP - 1)) begin
            out_data <= acc_nx;
            out_ch   <= grant;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler: table-driven impulse, DC, channel isolation,
// backpressure, latency/strobe and mid-MAC reset sequences, with a reference FIR scoreboard.
module tb_fir_channel_scheduler;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int NTAPS  = 22;

  logic              clk = 1'b0;
  logic              rst;
  logic              red_valid, ir_valid;
  logic [DATA_W-1:0] red_data, ir_data;
  logic              red_ready, ir_ready;
  logic              out_valid, out_ch, busy;
  logic [ACC_W-1:0]  out_data;

  fir_channel_scheduler #(.DATA_W(DATA_W), .ACC_W(ACC_W), .NTAPS(NTAPS)) dut (
    .CLK_Filter(clk), .rst(rst),
    .red_valid(red_valid), .red_data(red_data), .red_ready(red_ready),
    .ir_valid(ir_valid), .ir_data(ir_data), .ir_ready(ir_ready),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int coef [11] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};
  int tap [NTAPS];
  int cum [NTAPS+1];

  // Reference model: per-channel history, expected results queued at acceptance time.
  int hist [2][NTAPS];
  int exp_q0 [$];
  int exp_q1 [$];
  int xfer_t [$];
  int n_out_red = 0;
  int cyc = 0;

  task automatic model_clear();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < NTAPS; i++) hist[c][i] = 0;
    exp_q0.delete();
    exp_q1.delete();
    xfer_t.delete();
    n_out_red = 0;
  endtask

  task automatic accept(input int ch, input int d);
    int y;
    for (int i = NTAPS - 1; i > 0; i--) hist[ch][i] = hist[ch][i-1];
    hist[ch][0] = d;
    y = 0;
    for (int i = 0; i < NTAPS; i++) y += tap[i] * hist[ch][i];
    if (ch == 0) begin
      exp_q0.push_back(y);
      xfer_t.push_back(cyc);
    end else begin
      exp_q1.push_back(y);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst === 1'b0) begin
        if (out_valid === 1'b1) begin
          if (out_ch === 1'b0) begin
            n_out_red++;
            check("sb_red_pending", exp_q0.size() != 0, 1);
            if (exp_q0.size() != 0) check("sb_red_result", out_data, exp_q0.pop_front());
          end else begin
            check("sb_ir_pending", exp_q1.size() != 0, 1);
            if (exp_q1.size() != 0) check("sb_ir_result", out_data, exp_q1.pop_front());
          end
        end
        if (red_valid && red_ready) accept(0, int'(red_data));
        if (ir_valid && ir_ready)   accept(1, int'(ir_data));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    red_valid = 1'b0;
    ir_valid  = 1'b0;
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_out(input int max, output bit ok, output logic [ACC_W-1:0] d, output logic ch);
    ok = 1'b0;
    d  = '0;
    ch = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        d  = out_data;
        ch = out_ch;
      end
    end
  endtask

  task automatic send_red(input logic [DATA_W-1:0] v, input int exp_val, input string name);
    bit got, ok;
    logic [ACC_W-1:0] d;
    logic ch;
    @(posedge clk); #1;
    red_valid = 1'b1;
    red_data  = v;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (red_ready === 1'b1) got = 1'b1;
    end
    @(posedge clk); #1;
    red_valid = 1'b0;
    check({name, "_accept"}, got, 1);
    wait_out(20, ok, d, ch);
    check({name, "_strobe"}, ok, 1);
    if (ok) begin
      check(name, d, exp_val);
      check({name, "_ch"}, ch, 0);
    end
  endtask

  typedef struct {
    logic [DATA_W-1:0] din;
    int                exp;
  } vec_t;

  int imp_exp [23] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128,
                       128, 122, 111, 95, 78, 60, 43, 28, 16, 10, 2, 0};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [23];
    bit ok;
    logic [ACC_W-1:0] d, last_ir;
    logic ch;
    int cnt, ir_bad;
    logic [20:0] ov_bits, bz_bits;

    rst = 1'b1;
    red_valid = 1'b0; ir_valid = 1'b0;
    red_data = '0; ir_data = '0;

    for (int i = 0; i < NTAPS; i++) tap[i] = coef[(i < NTAPS/2) ? i : NTAPS - 1 - i];
    cum[0] = 0;
    for (int i = 1; i <= NTAPS; i++) cum[i] = cum[i-1] + tap[i-1];
    for (int i = 0; i < 23; i++) begin
      tbl[i].din = (i == 0) ? 8'd1 : 8'd0;
      tbl[i].exp = imp_exp[i];
    end
    model_clear();

    // Reset state
    @(negedge clk);
    check("rst_red_ready", red_ready, 1);
    check("rst_ir_ready", ir_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1. Impulse on RED
    for (int i = 0; i < 23; i++) send_red(tbl[i].din, tbl[i].exp, $sformatf("impulse_%0d", i));

    // 2. DC at full scale
    do_reset();
    for (int n = 1; n <= 30; n++)
      send_red(8'd255, 255 * cum[(n < NTAPS) ? n : NTAPS], $sformatf("dc_%0d", n));
    check("dc_steady", out_data, 353430);

    // 3. Channel isolation under continuous demand
    do_reset();
    @(posedge clk); #1;
    red_valid = 1'b1; red_data = 8'd0;
    ir_valid  = 1'b1; ir_data  = 8'd100;
    last_ir = '0;
    for (int i = 0; i < 48; i++) begin
      wait_out(40, ok, d, ch);
      check($sformatf("iso_strobe_%0d", i), ok, 1);
      if (ok) begin
        check($sformatf("iso_ch_%0d", i), ch, i % 2);
        if (i % 2 == 1) begin
          check($sformatf("iso_ir_%0d", i), d, 100 * cum[(i/2 + 1 < NTAPS) ? i/2 + 1 : NTAPS]);
          last_ir = d;
        end else begin
          check($sformatf("iso_red_%0d", i), d, 0);
        end
      end
    end
    check("iso_ir_steady", last_ir, 138600);
    @(posedge clk); #1;
    red_valid = 1'b0; ir_valid = 1'b0;
    repeat (40) @(posedge clk);

    // 4. Backpressure with an incrementing RED stream
    do_reset();
    ir_bad = 0;
    for (int c = 0; c < 130; c++) begin
      @(posedge clk); #1;
      red_valid = 1'b1;
      red_data  = 8'(c + 1);
      if (ir_ready !== 1'b1) ir_bad++;
    end
    @(posedge clk); #1;
    red_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("bp_ir_ready", ir_bad, 0);
    check("bp_xfer_count", xfer_t.size() >= 9, 1);
    for (int i = 2; i < xfer_t.size(); i++)
      check($sformatf("bp_interval_%0d", i), xfer_t[i] - xfer_t[i-1], 14);
    check("bp_out_count", n_out_red, xfer_t.size());
    check("bp_drained", exp_q0.size(), 0);

    // 5. Latency and strobe width from a single accept
    do_reset();
    @(posedge clk); #1;
    red_valid = 1'b1; red_data = 8'd1;
    @(negedge clk);
    check("lat_ready", red_ready, 1);
    @(posedge clk); #1;
    red_valid = 1'b0;
    ov_bits = '0; bz_bits = '0;
    ov_bits[0] = out_valid; bz_bits[0] = busy;
    for (int k = 1; k < 21; k++) begin
      @(posedge clk); #1;
      ov_bits[k] = out_valid;
      bz_bits[k] = busy;
      if (k == 13) check("lat_data", out_data, 2);
    end
    check("lat_out_valid_pattern", ov_bits, 21'h002000);
    check("lat_busy_pattern", bz_bits, 21'h003FFE);

    // 6. Reset during MAC step 5
    @(posedge clk); #1;
    red_valid = 1'b1; red_data = 8'd7;
    @(negedge clk);
    @(posedge clk); #1;
    red_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_busy_before", busy, 1);
    check("mid_out_data_before", out_data, 2);
    rst = 1'b1;
    model_clear();
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_out_data", out_data, 0);
    check("mid_red_ready", red_ready, 1);
    check("mid_ir_ready", ir_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid === 1'b1) cnt++;
    end
    check("mid_no_strobe", cnt, 0);
    send_red(8'd1, 2, "mid_impulse");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_channel_scheduler.md
Name: fir_channel_scheduler

Overview:
- Time-multiplexed symmetric 22-tap low-pass FIR shared between the RED and IR ADC sample streams of the pulse-oximeter front end.
- Each channel has a one-entry input holding register and a private 22-deep delay line.
- A round-robin scheduler grants one pending sample at a time to a single pre-add/multiply/accumulate unit, sequenced over 11 coefficient steps.
- Results are tagged with their channel. The block replaces two fully parallel filters and sits between the ADC interface and the SpO2 computation.

Parameters:
- DATA_W, 8, ADC sample width (unsigned).
- ACC_W, 20, accumulator and output width.
- NTAPS, 22, filter length. Must be even; NTAPS/2 coefficient steps.

Ports:
- CLK_Filter  in  1  filter clock; all state on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- red_valid  in  1  RED sample offered.
- red_data  in  DATA_W  RED sample.
- red_ready  out  1  RED holding register empty.
- ir_valid  in  1  IR sample offered.
- ir_data  in  DATA_W  IR sample.
- ir_ready  out  1  IR holding register empty.
- out_valid  out  1  one-cycle result strobe.
- out_ch  out  1  result channel: 0=RED, 1=IR.
- out_data  out  ACC_W  filtered result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Coefficients are fixed, indexed by step k = 0..10: 2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128.
- y = sum over k of coeff[k]*(x[k] + x[21-k]), where x[0] is the newest sample.
- Input handshake:
  - ch_ready = !hold_full[ch].
  - A transfer happens when valid&&ready at a rising edge; data is latched and hold_full is set.
  - hold_full is cleared by the SHIFT of that channel. ready rises the cycle after SHIFT, so there is no same-edge load-and-clear.
  - Valid held with ready low: no transfer, and no data is captured.
- FSM states: IDLE, SHIFT, MAC, DONE.
  - IDLE: if no hold_full, stay. If one channel is full, grant it. If both are full, grant the channel opposite last_grant. Record the grant and go to SHIFT.
  - SHIFT (1 cycle): the granted delay line shifts by one and line[0] takes the hold data. Clear hold_full, acc=0, step=0, then go to MAC.
  - MAC (11 cycles, step 0..10): acc += coeff[step]*(line[step]+line[21-step]).
    - Pre-add is 9 bits, product 17 bits, zero-extended to ACC_W.
    - Unsigned, no saturation; the maximum 353430 fits in 20 bits.
    - At step 10, go to DONE.
  - DONE (1 cycle): out_valid=1, out_data=acc (registered), out_ch=granted channel. Next state is IDLE.
- out_data and out_ch hold their values until the next DONE. out_valid is low outside DONE.
- Timing:
  - Service time is 14 cycles per sample.
  - With the engine idle, out_valid is asserted 13 cycles after the accepting edge.
  - Under continuous demand from both channels, each channel gets 1 result per 28 cycles.
- The non-granted channel's delay line and holding register are untouched during a service. A new sample may be accepted into a free holding register at any time, including mid-MAC.
- Reset, asynchronous and valid at any time including mid-MAC:
  - state=IDLE, both delay lines and holding registers zero, hold_full=0.
  - acc=0, step=0, last_grant=IR (so RED wins the first tie).
  - out_valid=0, out_ch=0, out_data=0, busy=0.
  - ready=1 on both channels while reset is asserted and after it releases.
  - A partial accumulation is discarded and no out_valid is produced.

Test Plan:
1. Impulse on RED: sample 1 then 21 zeros, one at a time -> 22 RED results 2,10,16,28,43,60,78,95,111,122,128,128,122,...,10,2, then 0.
2. DC: RED=255 continuously for 30 samples -> results ramp, then hold steady at 353430 from the 22nd result onward. No overflow.
3. Channel isolation: both valid from reset, RED=0 stream, IR=100 stream -> first out_ch=0 then alternating. RED stays 0. IR ramps, then steady at 138600.
4. Backpressure: red_valid held high with an incrementing counter on red_data -> exactly one transfer per 14 cycles. Output sequence matches the golden model with no lost or duplicated samples. ir_ready stays 1.
5. Latency/strobe: a single RED accept at edge E -> out_valid high exactly 1 cycle, 13 cycles after E. busy high for 13 cycles before it.
6. Reset mid-MAC: assert rst during MAC step 5 -> out_valid/out_data/busy go 0 immediately and no strobe is emitted. After release, an impulse of 1 yields 2 (history cleared).
